// File: rtl/store_size_control.sv
// -----------------------------------------------------------------------------
// store_size_control
//
// Writes a word, halfword or byte from the register file into memory.
// Word stores go straight to a single write cycle. Halfword and byte stores
// perform a read-modify-write: the target word is read, its low 16 or 8 bits
// are replaced by the register data, and the merged word is written back.
// The control unit holds its request until `done`.
//
// Parameters:
//   READ_LATENCY  cycles from MemAddr first presented until MemDataIn valid (1..4)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset, returns to IDLE
//   start       in   store request, accepted only in IDLE
//   Selector    in   [1:0] 00 word, 01 halfword, 10 byte, 11 invalid
//   Addr        in   [31:0] word address, latched at start
//   Data        in   [31:0] register data, latched at start
//   MemDataIn   in   [31:0] memory read data
//   MemAddr     out  [31:0] memory address (READ/MERGE/WRITE only, else 0)
//   MemWrite    out  write strobe, one cycle per store
//   MemDataOut  out  [31:0] write data (WRITE only, else 0)
//   busy        out  high in every state except IDLE
//   done        out  one-cycle completion pulse
//   error       out  one-cycle pulse on a rejected invalid selector
//
// Configuration macro:
//   STORE_SIZE_CONTROL_ERR_EN  when defined, Selector 11 is rejected with
//                              error+done; otherwise it is a word store and
//                              error is tied low.
//
// All outputs are decoded from registered state, so an asynchronous reset
// removes them (including MemWrite) in the same cycle it is asserted.
// -----------------------------------------------------------------------------
module store_size_control #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  Selector,
  input  logic [31:0] Addr,
  input  logic [31:0] Data,
  input  logic [31:0] MemDataIn,
  output logic [31:0] MemAddr,
  output logic        MemWrite,
  output logic [31:0] MemDataOut,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Counter is loaded with READ_LATENCY-1 so READ lasts exactly READ_LATENCY cycles.
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_BYTE = 2'b10;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [1:0]  cnt;
  logic [1:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] merged_q;
  logic        sub_word;

  // Halfword and byte stores need the read-modify-write path.
  assign sub_word = (sel_q == SEL_HALF) || (sel_q == SEL_BYTE);

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef STORE_SIZE_CONTROL_ERR_EN
          if (Selector == 2'b11) begin
            state_next = S_DONE;
          end else if ((Selector == SEL_HALF) || (Selector == SEL_BYTE)) begin
            state_next = S_READ;
          end else begin
            state_next = S_WRITE;
          end
`else
          if ((Selector == SEL_HALF) || (Selector == SEL_BYTE)) begin
            state_next = S_READ;
          end else begin
            state_next = S_WRITE;
          end
`endif
        end else begin
          state_next = S_IDLE;
        end
      end
      S_READ: begin
        if (cnt == 2'd0) begin
          state_next = S_MERGE;
        end else begin
          state_next = S_READ;
        end
      end
      S_MERGE: state_next = S_WRITE;
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, latency counter and store operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      sel_q    <= 2'b00;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      merged_q <= 32'd0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        sel_q  <= Selector;
        addr_q <= Addr;
        data_q <= Data;
        cnt    <= CNT_INIT;
      end else if (state == S_READ && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end else if (state == S_MERGE) begin
        if (sel_q == SEL_HALF) begin
          merged_q <= {MemDataIn[31:16], data_q[15:0]};
        end else begin
          merged_q <= {MemDataIn[31:8], data_q[7:0]};
        end
      end else begin
        cnt <= cnt;
      end
    end
  end

`ifdef STORE_SIZE_CONTROL_ERR_EN
  logic err_q;

  // Remembers that the current DONE comes from a rejected selector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err_q <= (Selector == 2'b11);
    end else if (state == S_DONE) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q;
    end
  end

  assign error = (state == S_DONE) && err_q;
`else
  assign error = 1'b0;
`endif

  // Output decode from the registered state.
  always_comb begin
    MemAddr    = 32'd0;
    MemWrite   = 1'b0;
    MemDataOut = 32'd0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_READ: MemAddr = addr_q;
      S_MERGE: MemAddr = addr_q;
      S_WRITE: begin
        MemAddr    = addr_q;
        MemWrite   = 1'b1;
        MemDataOut = sub_word ? merged_q : data_q;
      end
      S_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: doc/store_size_control.md
# store_size_control

Store-side counterpart to the load-size extractor. Writes a word, halfword or byte from the register file into memory. Word stores are written directly. Halfword and byte stores use a read-modify-write sequence: read the target word, replace its low 16 or 8 bits with the register data, then write the word back. The block sits between the control unit and the memory port, and the control unit holds its store state until `done`.

## Interface
- `READ_LATENCY`, default 1: cycles from `MemAddr` first presented until `MemDataIn` is valid; legal range 1–4.
- `clk` input 1: system clock, all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; returns the block to IDLE.
- `start` input 1: request a store; accepted only in IDLE.
- `Selector` input 2: store size; 00 word, 01 halfword, 10 byte, 11 invalid.
- `Addr` input 32: word address of the store, latched at start.
- `Data` input 32: register data, latched at start; halfword uses [15:0], byte uses [7:0].
- `MemDataIn` input 32: read data from memory.
- `MemAddr` output 32: memory address.
- `MemWrite` output 1: memory write strobe, high for exactly one cycle per store.
- `MemDataOut` output 32: memory write data.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `error` output 1: one-cycle pulse on a rejected invalid selector (only with the configuration macro).

## Operation
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE + start:
  - Latch `Addr`, `Data`, `Selector`.
  - Word → WRITE. Halfword or byte → READ.
  - Selector 11 → see Configuration.
- READ:
  - Drive `MemAddr` with the latched address.
  - Down-counter loaded with `READ_LATENCY`−1; stay in READ until it reaches 0, then → MERGE.
- MERGE:
  - Capture the merged word into the write register.
  - Halfword merge = {MemDataIn[31:16], Data[15:0]}.
  - Byte merge = {MemDataIn[31:8], Data[7:0]}.
  - → WRITE.
- WRITE:
  - `MemWrite` = 1, `MemAddr` = latched address.
  - `MemDataOut` = latched `Data` for word stores, merged word otherwise.
  - → DONE.
- DONE: `done` = 1, → IDLE.
- `start` outside IDLE is ignored and not queued.
- Input changes after start have no effect on the store in progress.
- Outside READ, MERGE and WRITE: `MemAddr` = 0. `MemDataOut` = 0 in every state except WRITE.
- No alignment check; `Addr` is used as given.

## Timing
- Reset values: state IDLE, `MemAddr` 0, `MemWrite` 0, `MemDataOut` 0, `busy` 0, `done` 0, `error` 0, latched registers 0. All outputs are decoded from registered state.
- With start sampled in cycle T and latency L = `READ_LATENCY`:
  - Word store: WRITE in T+1, `done` in T+2.
  - Halfword or byte store: READ in T+1 … T+L, MERGE in T+L+1 (`MemDataIn` sampled), WRITE in T+L+2, `done` in T+L+3.
  - With L = 1, `done` is in T+4.
- Earliest next accepted start is the cycle after `done`.
- Reset asserted mid-operation: outputs go to reset values immediately, with no partial write. A reset asserted during WRITE drops `MemWrite` in that same cycle.
- `start` in the same cycle that reset deasserts is ignored if reset is still sampled high at that edge.

## Configuration
- Macro: `STORE_SIZE_CONTROL_ERR_EN`.
- Defined: Selector 11 at start goes IDLE → DONE. `error` = 1 and `done` = 1 in the same cycle, no memory access, `busy` high for that one cycle.
- Undefined: Selector 11 is treated as a word store, and `error` is tied to 0.

## Test plan
- Word store, `READ_LATENCY`=1: Addr=0x40, Data=0xDEADBEEF, Selector=00 → `MemWrite` in T+1 with MemAddr=0x40, MemDataOut=0xDEADBEEF. `done` in T+2; no READ cycle.
- Halfword store: memory[0x40]=0x11223344, Data=0xAAAABBBB, Selector=01 → write 0x1122BBBB in T+3 and `done` in T+4.
- Byte store with `READ_LATENCY`=3: memory[0x80]=0x11223344, Data=0x000000CC, Selector=10 → write 0x112233CC in T+5 and `done` in T+6.
- Busy handling: start pulsed again in T+1 and T+2 of a halfword store → only one `MemWrite`, latched Addr and Data unchanged.
- Reset during READ of a byte store → `MemWrite` never asserted, `busy` 0 immediately. A new word store after reset completes normally.
- Selector=11 with the macro defined → `error` and `done` in T+1, no `MemWrite`. Without the macro → word write in T+1.
